shift_window_ctrl: RTL and testbench
====================================

Name: shift_window_ctrl

Overview:
- Sequencer for the 9x9 shifting window buffer that holds the 28x28 input image.
- Accepts a raster-order pixel stream through a valid/ready handshake and drives the buffer's shift controls, one shift per accepted pixel.
- Tracks image row/column and flags each cycle where the buffer holds a complete window for the mult-adder tree.
- Stalls the stream while the downstream consumer has not taken the presented window.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- KERN_W, 9, window width.
- KERN_H, 9, window height.
- CNT_W, 5, width of the row/column counters; must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a new frame.
- pix_valid  in  1  upstream pixel present on the buffer input.
- pix_ready  out  1  controller accepts the pixel this cycle.
- shift_en  out  1  buffer shift enable.
- shift_dir  out  1  buffer shift direction; 1 = width (right-to-left) path.
- win_valid  out  1  buffer holds a complete window.
- win_ready  in  1  mult-adder tree consumes the window.
- win_row  out  CNT_W  image row of the window's bottom-right pixel.
- win_col  out  CNT_W  image column of the window's bottom-right pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is fully processed.

Behaviour:
- FSM states: IDLE, LOAD, HOLD, DONE. Reset forces IDLE and clears row/col counters.
- Reset values: pix_ready=0, shift_en=0, shift_dir=1, win_valid=0, win_row=0, win_col=0, frame_done=0.
- shift_dir is held at 1 at all times.
- IDLE:
  - pix_ready=0.
  - frame_start=1 moves to LOAD next cycle with row=col=0.
  - A pix_valid in the same cycle as frame_start is not accepted.
- LOAD:
  - pix_ready=1.
  - accept = pix_valid & pix_ready.
  - shift_en = accept, combinational, in the same cycle, so the buffer captures the pixel in that cycle.
- Counter update on each accept:
  - col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
- Window qualification: an accepted pixel at (r,c) qualifies when r >= KERN_H-1 and c >= KERN_W-1.
  - On a qualifying accept: next cycle win_valid=1, win_row=r, win_col=c, state HOLD.
  - Latency is exactly 1 cycle.
- HOLD:
  - pix_ready=0 and shift_en=0.
  - win_valid, win_row and win_col stay stable until win_ready=1.
  - On win_valid & win_ready: win_valid=0 next cycle. Next state is LOAD, or DONE if the window's pixel was (IMG_H-1, IMG_W-1).
- Last pixel of a frame:
  - If (IMG_H-1, IMG_W-1) does not qualify (not possible with the defaults), its accept goes directly to DONE.
- DONE:
  - frame_done=1 for one cycle, then IDLE.
  - The defaults give 400 windows per frame.
- frame_start while in LOAD or HOLD:
  - Aborts the frame: win_valid=0 and counters cleared next cycle, state LOAD.
  - No frame_done is issued.
  - Any pixel offered in that cycle is not accepted (pix_ready is forced 0 in that cycle).
- frame_start in DONE is honoured: next state LOAD, not IDLE.
- win_ready while win_valid=0 is ignored.
- Reset asserted mid-frame overrides everything; outputs take their reset values on the next edge.

Optional Feature:
- Macro: SHIFT_WINDOW_CTRL_STALL_CNT_EN.
- With the macro defined: an extra output port stall_cycles [15:0].
  - Counts cycles spent in HOLD with win_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by frame_start.
  - Holds its value in IDLE.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then frame_start, then 784 pixels with pix_valid=1 and win_ready=1 constantly:
  - exactly 400 win_valid pulses;
  - first at (8,8), last at (27,27);
  - frame_done one cycle after the last handshake.
- First pixel accept:
  - shift_en high in the same cycle, shift_dir=1;
  - no win_valid before pixel (8,8) is accepted;
  - win_valid rises exactly 1 cycle after that accept.
- win_ready held 0 for 5 cycles on window (8,8):
  - pix_ready=0 and win_row/win_col stable at 8/8 throughout;
  - with the macro defined, stall_cycles=5.
- pix_valid toggled 1-0-1 randomly mid-row:
  - counters advance only on accepts;
  - window positions still exactly (8..27, 8..27).
- frame_start asserted mid-frame at pixel (15,3), then a full frame:
  - no frame_done for the aborted frame;
  - the new frame's first window is at (8,8).
- reset asserted in HOLD:
  - next cycle win_valid=0, pix_ready=0, state IDLE;
  - frame_start alone then restarts cleanly.

Source files
------------

// File: rtl/shift_window_ctrl.sv
// Sequencer for the 9x9 shifting window buffer: one buffer shift per accepted raster pixel, flags full windows.
// Latency: shift_en is combinational with the pixel handshake; win_valid rises 1 cycle after the qualifying accept.
// Backpressure: pix_ready drops while a window waits for win_ready; optional stall counter under SHIFT_WINDOW_CTRL_STALL_CNT_EN.
module shift_window_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int KERN_W = 9,
    parameter int KERN_H = 9,
    parameter int CNT_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             shift_en,
    output logic             shift_dir,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             frame_done
`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] COL_MIN  = CNT_W'(KERN_W - 1);
    localparam logic [CNT_W-1:0] ROW_MIN  = CNT_W'(KERN_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;

    logic accept;
    logic pix_is_last;
    logic pix_qualifies;
    logic win_is_last;

    assign pix_is_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign pix_qualifies = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    assign win_is_last   = (win_row_q == ROW_LAST) && (win_col_q == COL_LAST);

    // Next-state, counter and handshake logic; frame_start in any active state restarts the frame.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        pix_ready   = 1'b0;
        accept      = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            LOAD: begin
                // A restart cycle never takes a pixel, so the new frame starts at (0,0).
                pix_ready = !frame_start;
                accept    = pix_valid && !frame_start;
                if (frame_start) begin
                    state_d     = LOAD;
                    row_d       = '0;
                    col_d       = '0;
                    win_valid_d = 1'b0;
                end else if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = pix_is_last ? '0 : row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                    if (pix_qualifies) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q;
                        win_col_d   = col_q;
                        state_d     = HOLD;
                    end else if (pix_is_last) begin
                        state_d = DONE;
                    end
                end
            end

            HOLD: begin
                if (frame_start) begin
                    state_d     = LOAD;
                    row_d       = '0;
                    col_d       = '0;
                    win_valid_d = 1'b0;
                end else if (win_valid_q && win_ready) begin
                    win_valid_d = 1'b0;
                    state_d     = win_is_last ? DONE : LOAD;
                end
            end

            DONE: begin
                frame_done = 1'b1;
                if (frame_start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                win_valid_d = 1'b0;
            end
        endcase
    end

    assign shift_en  = accept;
    assign shift_dir = 1'b1;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

    // State, position counters and presented-window registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles a window waited on the consumer; restarts with each frame.
    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = '0;
        end else if ((state_q == HOLD) && !win_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Directed bench for shift_window_ctrl: vector table for handshake basics, frame sequences for multi-cycle cases.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_shift_window_ctrl;

    logic       clock;
    logic       reset;
    logic       frame_start;
    logic       pix_valid;
    logic       pix_ready;
    logic       shift_en;
    logic       shift_dir;
    logic       win_valid;
    logic       win_ready;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       frame_done;
`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int nvec = 0;
    int nerr = 0;

    shift_window_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .shift_en    (shift_en),
        .shift_dir   (shift_dir),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_col     (win_col),
        .frame_done  (frame_done)
`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst;
        logic fs;
        logic pv;
        logic wr;
        logic pr;
        logic se;
        logic wv;
        int   row;
        int   col;
        logic fd;
    } vec_t;

    vec_t tbl[10];

    // Runs one frame starting with a frame_start pulse. abort_at >= 0 restarts the frame once that many
    // pixels are in; stall_n holds win_ready low for that many cycles on the first window.
    task automatic run_frame(input bit rand_pv, input int abort_at, input int stall_n);
        int nacc, widx, stall_left, er, ec;
        bit prev_wv, prev_se, prev_hs, hs, done_seen, aborted, first_acc_seen;
        @(posedge clock); #1;
        reset = 1'b0; frame_start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        @(negedge clock);
        chk("start_cycle_shift_en", shift_en, 0);
        nacc = 0; widx = 0; stall_left = stall_n;
        prev_wv = 0; prev_se = 0; prev_hs = 0; done_seen = 0;
        aborted = (abort_at < 0); first_acc_seen = 0;
        for (int cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
            @(posedge clock); #1;
            frame_start = 1'b0;
            pix_valid   = rand_pv ? ($urandom_range(0, 2) != 0) : 1'b1;
            win_ready   = 1'b1;
            if (win_valid && stall_left > 0) win_ready = 1'b0;
            if (!aborted && nacc == abort_at && !win_valid) frame_start = 1'b1;
            @(negedge clock);
            if (frame_start) begin
                chk("abort_pix_ready", pix_ready, 0);
                chk("abort_shift_en", shift_en, 0);
                aborted = 1; nacc = 0; widx = 0;
                prev_wv = 0; prev_se = 0; prev_hs = 0;
                continue;
            end
            er = 8 + widx / 20;
            ec = 8 + widx % 20;
            if (!win_ready) begin
                stall_left--;
                chk("stall_pix_ready", pix_ready, 0);
                chk("stall_win_row", win_row, er);
                chk("stall_win_col", win_col, ec);
            end
            if (shift_en) begin
                if (!first_acc_seen) begin
                    first_acc_seen = 1;
                    chk("first_accept_shift_dir", shift_dir, 1);
                    chk("first_accept_pix_valid", pix_valid, 1);
                end
                nacc++;
            end
            if (win_valid && !prev_wv) begin
                chk("win_latency_prev_accept", prev_se, 1);
                chk("win_row", win_row, er);
                chk("win_col", win_col, ec);
                chk("win_accept_count", nacc, er * 28 + ec + 1);
                chk("win_hold_pix_ready", pix_ready, 0);
            end
            if (frame_done) begin
                chk("done_window_count", widx, 400);
                chk("done_after_last_handshake", prev_hs, 1);
                done_seen = 1;
            end
            hs = win_valid && win_ready;
            if (hs) widx++;
            prev_wv = win_valid;
            prev_se = shift_en;
            prev_hs = hs;
        end
        chk("frame_done_seen", done_seen, 1);
        chk("pixels_accepted", nacc, 784);
`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stall_n);
`endif
        @(posedge clock); #1;
        pix_valid = 1'b1; win_ready = 1'b1;
        @(negedge clock);
        chk("idle_after_done_pix_ready", pix_ready, 0);
        chk("frame_done_one_cycle", frame_done, 0);
    endtask

    initial begin
        bit got_win;
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
        repeat (2) @(posedge clock);

        //           rst fs pv wr | pr se wv row col fd
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}; // in reset
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}; // idle ignores pixels
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}; // start: pixel not taken
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0}; // accept (0,0)
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0}; // no pixel offered
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0}; // accept (0,1)
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}; // restart in LOAD
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0}; // accept again
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0}; // reset sampled at edge
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0}; // back in idle

        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            reset = tbl[i].rst; frame_start = tbl[i].fs;
            pix_valid = tbl[i].pv; win_ready = tbl[i].wr;
            @(negedge clock);
            chk($sformatf("vec%0d_pix_ready", i), pix_ready, tbl[i].pr);
            chk($sformatf("vec%0d_shift_en", i), shift_en, tbl[i].se);
            chk($sformatf("vec%0d_shift_dir", i), shift_dir, 1);
            chk($sformatf("vec%0d_win_valid", i), win_valid, tbl[i].wv);
            chk($sformatf("vec%0d_win_row", i), win_row, tbl[i].row);
            chk($sformatf("vec%0d_win_col", i), win_col, tbl[i].col);
            chk($sformatf("vec%0d_frame_done", i), frame_done, tbl[i].fd);
        end

        // Full frame, first window held off for 5 cycles.
        run_frame(1'b0, -1, 5);
        // Gappy pixel stream.
        run_frame(1'b1, -1, 0);
        // Restart at pixel (15,3), then a complete frame.
        run_frame(1'b0, 15 * 28 + 3, 0);

        // Reset while a window is held.
        @(posedge clock); #1;
        frame_start = 1'b1; pix_valid = 1'b1; win_ready = 1'b0;
        got_win = 0;
        for (int cyc = 0; cyc < 1000 && !got_win; cyc++) begin
            @(posedge clock); #1;
            frame_start = 1'b0;
            @(negedge clock);
            got_win = win_valid;
        end
        chk("hold_reached_before_reset", got_win, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; pix_valid = 1'b1; win_ready = 1'b1;
        @(negedge clock);
        chk("reset_in_hold_win_valid", win_valid, 0);
        chk("reset_in_hold_pix_ready", pix_ready, 0);
        chk("reset_in_hold_win_row", win_row, 0);
        chk("reset_in_hold_win_col", win_col, 0);
`ifdef SHIFT_WINDOW_CTRL_STALL_CNT_EN
        chk("reset_in_hold_stall_cycles", stall_cycles, 0);
`endif
        run_frame(1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
